// File: rtl/pwm_pkg.sv
// Shared types and defaults for the dead-time PWM generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DT_W_DEF  = 8;

  // Gate-drive sequencer states: both off, high side on, high->low gap,
  // low side on, low->high gap.
  typedef enum logic [2:0] {
    OFF   = 3'd0,
    HI    = 3'd1,
    DT_HL = 3'd2,
    LO    = 3'd3,
    DT_LH = 3'd4
  } pwm_state_t;

endpackage

// File: rtl/pwm_dead_time.sv
// Dead-time inserter: turns raw PWM into non-overlapping high/low gate drives.
// Latency: falling side drops 1 clk after a raw edge, other side rises dead+1 clks after it.
// Backpressure: none; follows raw every cycle, forced OFF while i_en=0.
module pwm_dead_time
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_raw,
  input  logic [DT_W-1:0] i_dead_act,
  output logic            o_ctrl,
  output logic            o_ctrl_n
);

  pwm_state_t      r_state;
  pwm_state_t      w_state_nxt;
  logic [DT_W-1:0] r_dcnt;
  logic [DT_W-1:0] w_dcnt_nxt;
  logic            r_ctrl;
  logic            r_ctrl_n;

  // Next state and gap counter; a gap always runs to completion, then the
  // side is chosen from raw at that moment (so a short glitch re-enters).
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    if (!i_en) begin
      w_state_nxt = OFF;
      w_dcnt_nxt  = '0;
    end else begin
      case (r_state)
        OFF: begin
          w_state_nxt = i_raw ? HI : LO;
        end
        HI: begin
          if (!i_raw) begin
            if (i_dead_act == '0) begin
              w_state_nxt = LO;
            end else begin
              w_state_nxt = DT_HL;
              w_dcnt_nxt  = i_dead_act;
            end
          end
        end
        LO: begin
          if (i_raw) begin
            if (i_dead_act == '0) begin
              w_state_nxt = HI;
            end else begin
              w_state_nxt = DT_LH;
              w_dcnt_nxt  = i_dead_act;
            end
          end
        end
        DT_HL, DT_LH: begin
          if (r_dcnt <= DT_W'(1)) begin
            w_state_nxt = i_raw ? HI : LO;
            w_dcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt  = r_dcnt - DT_W'(1);
          end
        end
        default: begin
          w_state_nxt = OFF;
          w_dcnt_nxt  = '0;
        end
      endcase
    end
  end

  // State, gap counter and gate drives; drives are decoded from the next
  // state so they are registered yet always match the current state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= OFF;
      r_dcnt   <= '0;
      r_ctrl   <= 1'b0;
      r_ctrl_n <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_ctrl   <= (w_state_nxt == HI);
      r_ctrl_n <= (w_state_nxt == LO);
    end
  end

  assign o_ctrl   = r_ctrl;
  assign o_ctrl_n = r_ctrl_n;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Period/duty PWM generator with shadowed settings and dead-time gate drives.
// Latency: settings apply at period wrap (or at once while disabled); outputs lag raw by 1 clk.
// Backpressure: none; load strobes are always accepted.
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W  = DT_W_DEF
) (
  input  logic             emu_clk,
  input  logic             emu_rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [DT_W-1:0]  dead,
  input  logic             load,
  output logic             ctrl,
  output logic             ctrl_n,
  output logic             cyc_start
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_sh;
  logic [CNT_W-1:0] r_duty_sh;
  logic [DT_W-1:0]  r_dead_sh;
  logic [CNT_W-1:0] r_period_act;
  logic [CNT_W-1:0] r_duty_act;
  logic [DT_W-1:0]  r_dead_act;
  logic             r_cyc_start;

  logic             w_wrap;
  logic             w_act_upd;
  logic             w_raw;
  logic             w_ctrl;
  logic             w_ctrl_n;

  // Wrap ends a running period; while disabled the active set tracks the
  // shadows every cycle so a fresh enable starts with current settings.
  assign w_wrap    = en && (r_cnt == r_period_act);
  assign w_act_upd = !en || w_wrap;
  assign w_raw     = (r_cnt < r_duty_act);

  // Shadow capture on every load strobe, regardless of enable.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_period_sh <= '0;
      r_duty_sh   <= '0;
      r_dead_sh   <= '0;
    end else if (load) begin
      r_period_sh <= period;
      r_duty_sh   <= duty;
      r_dead_sh   <= dead;
    end
  end

  // Active settings; a load landing on the update cycle bypasses the shadow
  // so it is not delayed by a whole period.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_period_act <= '0;
      r_duty_act   <= '0;
      r_dead_act   <= '0;
    end else if (w_act_upd) begin
      if (load) begin
        r_period_act <= period;
        r_duty_act   <= duty;
        r_dead_act   <= dead;
      end else begin
        r_period_act <= r_period_sh;
        r_duty_act   <= r_duty_sh;
        r_dead_act   <= r_dead_sh;
      end
    end
  end

  // Period counter, parked at zero while disabled.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_cnt <= '0;
    end else if (!en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // One-clock cycle-start marker, registered from the count==0 cycle.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_cyc_start <= 1'b0;
    end else begin
      r_cyc_start <= en && (r_cnt == '0);
    end
  end

  pwm_dead_time #(
    .DT_W (DT_W)
  ) u_dead_time (
    .i_clk      (emu_clk),
    .i_rst_n    (emu_rst_n),
    .i_en       (en),
    .i_raw      (w_raw),
    .i_dead_act (r_dead_act),
    .o_ctrl     (w_ctrl),
    .o_ctrl_n   (w_ctrl_n)
  );

  assign ctrl      = w_ctrl;
  assign ctrl_n    = w_ctrl_n;
  assign cyc_start = r_cyc_start;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: directed scenarios plus random settings/enable/reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pwm_deadtime_gen;

  localparam int CNT_W = 16;
  localparam int DT_W  = 8;

  logic             emu_clk;
  logic             emu_rst_n;
  logic             en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic [DT_W-1:0]  dead;
  logic             load;
  logic             ctrl;
  logic             ctrl_n;
  logic             cyc_start;

  pwm_deadtime_gen #(
    .CNT_W (CNT_W),
    .DT_W  (DT_W)
  ) dut (
    .emu_clk   (emu_clk),
    .emu_rst_n (emu_rst_n),
    .en        (en),
    .period    (period),
    .duty      (duty),
    .dead      (dead),
    .load      (load),
    .ctrl      (ctrl),
    .ctrl_n    (ctrl_n),
    .cyc_start (cyc_start)
  );

  initial begin
    emu_clk = 1'b0;
    forever #5 emu_clk = ~emu_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: counter position, settings, and which gate side is
  // asserted plus how many gap cycles are left before a side is chosen.
  int m_cnt, m_per, m_duty, m_dead, m_per_sh, m_duty_sh, m_dead_sh;
  int m_cs;
  int m_side;  // 0 none, 1 high side, 2 low side
  int m_gap;   // remaining dead-time cycles; outputs low while > 0

  task automatic model_reset();
    m_cnt = 0; m_per = 0; m_duty = 0; m_dead = 0;
    m_per_sh = 0; m_duty_sh = 0; m_dead_sh = 0;
    m_cs = 0; m_side = 0; m_gap = 0;
  endtask

  task automatic model_step();
    int  raw;
    int  wrap;
    int  n_side;
    int  n_gap;
    if (!emu_rst_n) begin
      model_reset();
      return;
    end
    raw    = (m_cnt < m_duty) ? 1 : 0;
    wrap   = (en && m_cnt == m_per) ? 1 : 0;
    n_side = m_side;
    n_gap  = m_gap;
    if (!en) begin
      n_side = 0;
      n_gap  = 0;
    end else if (m_side == 0) begin
      n_side = raw ? 1 : 2;
    end else if (m_gap > 0) begin
      if (m_gap == 1) begin
        n_gap  = 0;
        n_side = raw ? 1 : 2;
      end else begin
        n_gap = m_gap - 1;
      end
    end else if ((m_side == 1 && !raw) || (m_side == 2 && raw)) begin
      if (m_dead == 0) n_side = raw ? 1 : 2;
      else             n_gap  = m_dead;
    end
    m_cs  = (en && m_cnt == 0) ? 1 : 0;
    m_cnt = (!en || wrap) ? 0 : m_cnt + 1;
    if (!en || wrap) begin
      if (load) begin
        m_per = int'(period); m_duty = int'(duty); m_dead = int'(dead);
      end else begin
        m_per = m_per_sh; m_duty = m_duty_sh; m_dead = m_dead_sh;
      end
    end
    if (load) begin
      m_per_sh = int'(period); m_duty_sh = int'(duty); m_dead_sh = int'(dead);
    end
    m_side = n_side;
    m_gap  = n_gap;
  endtask

  // Window statistics gathered over ticks.
  int w_hi, w_lo, w_cs, w_gap;

  task automatic win_clear();
    w_hi = 0; w_lo = 0; w_cs = 0; w_gap = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge emu_clk);
    #1;
    chk("ctrl", int'(ctrl), (m_side == 1 && m_gap == 0) ? 1 : 0);
    chk("ctrl_n", int'(ctrl_n), (m_side == 2 && m_gap == 0) ? 1 : 0);
    chk("cyc_start", int'(cyc_start), m_cs);
    chk("no_overlap", int'(ctrl & ctrl_n), 0);
    w_hi  += int'(ctrl);
    w_lo  += int'(ctrl_n);
    w_cs  += int'(cyc_start);
    w_gap += int'(!ctrl && !ctrl_n);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input int p, input int d, input int t);
    period = CNT_W'(p);
    duty   = CNT_W'(d);
    dead   = DT_W'(t);
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  // Align to the cycle where the count is 0 (period 9 assumed).
  task automatic sync_cs(input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cyc_start) begin
        found = 1;
        break;
      end
    end
    chk(tag, found, 1);
    ticks(9);
  endtask

  task automatic async_reset_pulse(input int hold);
    #3;
    emu_rst_n = 1'b0;
    #1;
    chk("rst_ctrl", int'(ctrl), 0);
    chk("rst_ctrl_n", int'(ctrl_n), 0);
    chk("rst_cyc_start", int'(cyc_start), 0);
    model_reset();
    ticks(hold);
    #3;
    emu_rst_n = 1'b1;
  endtask

  initial begin
    int prev;
    int found;
    emu_rst_n = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    period    = '0;
    duty      = '0;
    dead      = '0;
    model_reset();
    #2;
    chk("reset_ctrl", int'(ctrl), 0);
    chk("reset_ctrl_n", int'(ctrl_n), 0);
    chk("reset_cyc_start", int'(cyc_start), 0);
    ticks(2);
    #3;
    emu_rst_n = 1'b1;
    ticks(2);

    // 50% duty, no dead time
    cfg(9, 5, 0);
    en = 1'b1;
    ticks(30);
    win_clear(); ticks(10);
    chk("d5_dt0_hi", w_hi, 5);
    chk("d5_dt0_lo", w_lo, 5);
    chk("d5_dt0_cs", w_cs, 1);

    // dead time of 2
    cfg(9, 5, 2);
    ticks(30);
    win_clear(); ticks(10);
    chk("d5_dt2_hi", w_hi, 3);
    chk("d5_dt2_lo", w_lo, 3);
    chk("d5_dt2_gap", w_gap, 4);
    chk("d5_dt2_cs", w_cs, 1);

    // duty extremes
    cfg(9, 0, 0);
    ticks(30);
    win_clear(); ticks(10);
    chk("d0_hi", w_hi, 0);
    chk("d0_lo", w_lo, 10);
    cfg(9, 12, 0);
    ticks(30);
    win_clear(); ticks(10);
    chk("d12_hi", w_hi, 10);
    chk("d12_lo", w_lo, 0);

    // mid-cycle load waits for wrap; wrap-coincident load applies at once
    cfg(9, 5, 0);
    ticks(30);
    sync_cs("sync1_timeout");
    win_clear();
    ticks(3);
    duty = CNT_W'(2); load = 1'b1;
    tick();
    load = 1'b0;
    ticks(6);
    chk("midload_cur_hi", w_hi, 5);
    win_clear(); ticks(10);
    chk("midload_next_hi", w_hi, 2);
    ticks(9);
    duty = CNT_W'(7); load = 1'b1;
    tick();
    load = 1'b0;
    win_clear(); ticks(10);
    chk("wrapload_hi", w_hi, 7);

    // short high pulse swallowed by dead time
    cfg(9, 1, 3);
    ticks(30);
    win_clear(); ticks(10);
    chk("glitch_hi", w_hi, 0);
    chk("glitch_lo", w_lo, 7);

    // reset during the high->low gap
    cfg(9, 5, 3);
    ticks(30);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      prev = int'(ctrl);
      tick();
      if (prev == 1 && !ctrl && !ctrl_n) begin
        found = 1;
        break;
      end
    end
    chk("dthl_timeout", found, 1);
    async_reset_pulse(2);
    tick();
    chk("post_rst_cs", int'(cyc_start), 1);
    ticks(3);

    // enable dropped mid-cycle, then restarted
    cfg(9, 5, 2);
    ticks(25);
    en = 1'b0;
    tick();
    chk("en_off_ctrl", int'(ctrl), 0);
    chk("en_off_ctrl_n", int'(ctrl_n), 0);
    chk("en_off_cs", int'(cyc_start), 0);
    ticks(2);
    en = 1'b1;
    tick();
    chk("en_on_cs", int'(cyc_start), 1);
    ticks(12);

    // random settings, enable toggles and occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        period = CNT_W'($urandom_range(0, 15));
        duty   = CNT_W'($urandom_range(0, 18));
        dead   = DT_W'($urandom_range(0, 5));
        load   = 1'b1;
      end
      if ($urandom_range(0, 79) == 0) en = ~en;
      tick();
      load = 1'b0;
      if ($urandom_range(0, 399) == 0) async_reset_pulse(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving period/duty counter width.
REQ-002 The block SHALL have parameter DT_W, default 8, giving dead-time counter width.
REQ-003 The block SHALL have port emu_clk, input, 1, the single clock; all state on its rising edge.
REQ-004 The block SHALL have port emu_rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, run enable.
REQ-006 The block SHALL have port period, input, CNT_W, cycle length minus one in emu_clk counts.
REQ-007 The block SHALL have port duty, input, CNT_W, number of high counts per cycle.
REQ-008 The block SHALL have port dead, input, DT_W, dead-time in emu_clk counts.
REQ-009 The block SHALL have port load, input, 1, a strobe that captures period/duty/dead into shadow registers.
REQ-010 The block SHALL have port ctrl, output, 1, high-side gate drive, which feeds the filter stage's ctrl input.
REQ-011 The block SHALL have port ctrl_n, output, 1, complementary low-side gate drive.
REQ-012 The block SHALL have port cyc_start, output, 1, a one-cycle pulse at each cycle start.

Function
REQ-013 The shadow registers SHALL capture period/duty/dead on any cycle with load=1, independent of en.
REQ-014 The active registers SHALL update from shadow only at wrap (cnt==period_act while running) or on every cycle while en=0.
REQ-015 When load=1 coincides with wrap, the active registers SHALL take the load-cycle input values directly, with no one-period delay.
REQ-016 While en=1, counter cnt SHALL increment 0..period_act and then wrap to 0; period_act=0 gives a 1-count cycle.
REQ-017 cyc_start SHALL be registered and SHALL be high for exactly one emu_clk in the cycle after cnt==0 while en=1.
REQ-018 Raw PWM SHALL be raw = (cnt < duty_act), compared unsigned; duty_act=0 gives constant low and duty_act>period_act gives constant high.
REQ-019 The dead-time FSM SHALL have states OFF, HI, DT_HL, LO and DT_LH.
REQ-020 FSM transitions SHALL be OFF->HI or OFF->LO per raw when en=1; HI->DT_HL on raw=0; LO->DT_LH on raw=1.
REQ-021 DT_HL/DT_LH SHALL load dead_act on entry, hold for dead_act cycles, then go to HI if raw=1 else LO.
REQ-022 When dead_act=0, HI<->LO SHALL switch directly with no DT state.
REQ-023 If raw returns to the previous level during a DT state, that DT state SHALL still complete and then re-enter the previous side.
REQ-024 ctrl SHALL be registered and equal (state==HI); ctrl_n SHALL be registered and equal (state==LO).
REQ-025 ctrl and ctrl_n SHALL never be high simultaneously in any cycle.
REQ-026 Latency from a raw edge to the opposite output rising SHALL be dead_act+1 emu_clk; the falling output SHALL drop 1 emu_clk after the raw edge.
REQ-027 On en 1->0, the next edge SHALL set cnt=0 and state=OFF, and drive ctrl=ctrl_n=cyc_start=0.
REQ-028 On en 0->1, the first running cycle SHALL have cnt=0, and cyc_start SHALL pulse one cycle later.

Reset
REQ-029 Asserting emu_rst_n=0 SHALL immediately, asynchronously, clear cnt, shadow/active period, duty and dead, the dead counter, ctrl, ctrl_n and cyc_start, and force state=OFF.
REQ-030 Reset mid-cycle or mid-DT SHALL abandon the cycle; after release with en=1, operation SHALL restart from cnt=0 using the zeroed settings until the next load.

Structure
REQ-031 Shared package pwm_pkg SHALL hold the FSM state enum typedef and the default CNT_W/DT_W constants.
REQ-032 The FSM, dead counter and output registers SHALL be in sub-module pwm_dead_time, which takes raw, dead_act and en and produces ctrl/ctrl_n.
REQ-033 The counter, shadow/active registers and cyc_start SHALL reside in pwm_deadtime_gen.

Verification
REQ-034 Bench SHALL cover: load period=9, duty=5, dead=0, en=1 -> ctrl high 5 of every 10 clocks, ctrl_n high 5, cyc_start every 10 clocks.
REQ-035 Bench SHALL cover: period=9, duty=5, dead=2 -> ctrl high 3 clocks, ctrl_n high 3 clocks, 2-clock gaps with both outputs low, never overlapping.
REQ-036 Bench SHALL cover: duty=0 -> ctrl stays 0, ctrl_n stays 1; duty=12 with period=9 -> ctrl stays 1, ctrl_n stays 0.
REQ-037 Bench SHALL cover: load duty=2 mid-cycle with duty=5 active -> current cycle keeps 5 high counts and the next cycle has 2; load coinciding with wrap -> new value takes effect immediately.
REQ-038 Bench SHALL cover: period=9, duty=1, dead=3 -> glitch case where ctrl_n re-enters after DT_LH and ctrl never rises.
REQ-039 Bench SHALL cover: emu_rst_n pulsed low during DT_HL, and en dropped mid-cycle -> both outputs 0 on the next edge, and restart with cnt=0.
